// File: rtl/rx_burst_sequencer.sv
// Burst receive sequencer: confirms a multi-phase packet detection, opens a
// fixed-length capture window, then blanks detections for a holdoff period.
module rx_burst_sequencer #(
  parameter int PHASES = 16,
  parameter int CNT_W  = 16,
  parameter int CONF_W = 4,
  localparam int PH_W  = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [PHASES-1:0] detection_i,
  input  logic [CONF_W-1:0] confirm_len_i,
  input  logic [CNT_W-1:0]  capture_len_i,
  input  logic [CNT_W-1:0]  holdoff_len_i,
  output logic              capture_en_o,
  output logic              frame_start_o,
  output logic [PH_W-1:0]   start_phase_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic              busy_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    CONFIRM = 3'd2,
    CAPTURE = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cap_len_q, hold_len_q;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [CONF_W:0]   conf_inc;
  logic              start_frame;
  logic              det_any;

  // Lowest-index phase wins: one-hot of the first set bit, then encode.
  logic [PHASES-1:0] lower_any, first_hit;
  logic [PH_W-1:0]   phase_idx;

  genvar g;
  generate
    for (g = 0; g < PHASES; g++) begin : g_first
      if (g == 0) begin : g_lsb
        assign lower_any[g] = 1'b0;
      end else begin : g_up
        assign lower_any[g] = lower_any[g-1] | detection_i[g-1];
      end
      assign first_hit[g] = detection_i[g] & ~lower_any[g];
    end
  endgenerate

  always_comb begin
    phase_idx = '0;
    for (int i = 0; i < PHASES; i++)
      if (first_hit[i]) phase_idx = phase_idx | PH_W'(i);
  end

  assign det_any  = |detection_i;
  assign conf_inc = {1'b0, conf_q} + {{CONF_W{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    conf_d      = conf_q;
    start_frame = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      conf_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEARCH;
        SEARCH: begin
          if (det_any) begin
            if (confirm_len_i <= CONF_W'(1)) begin
              start_frame = 1'b1;
            end else begin
              state_d = CONFIRM;
              conf_d  = CONF_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (det_any) begin
            if (conf_inc >= {1'b0, confirm_len_i}) start_frame = 1'b1;
            else conf_d = conf_inc[CONF_W-1:0];
          end else begin
            state_d = SEARCH;
            conf_d  = '0;
          end
        end
        // cnt_q is 1 on the first window cycle, so a zero length still gives one cycle.
        CAPTURE: begin
          if (cnt_q >= cap_len_q) begin
            if (hold_len_q == '0) begin
              state_d = SEARCH;
              cnt_d   = '0;
            end else begin
              state_d = HOLDOFF;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt_q >= hold_len_q) begin
            state_d = SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      if (start_frame) begin
        state_d = CAPTURE;
        cnt_d   = CNT_W'(1);
        conf_d  = '0;
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      conf_q        <= '0;
      cap_len_q     <= '0;
      hold_len_q    <= '0;
      capture_en_o  <= 1'b0;
      frame_start_o <= 1'b0;
      start_phase_o <= '0;
      frame_cnt_o   <= '0;
      busy_o        <= 1'b0;
      state_o       <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      conf_q        <= conf_d;
      capture_en_o  <= (state_d == CAPTURE);
      frame_start_o <= start_frame;
      busy_o        <= (state_d == CONFIRM) || (state_d == CAPTURE) || (state_d == HOLDOFF);
      state_o       <= state_d;
      if (start_frame) begin
        cap_len_q     <= capture_len_i;
        hold_len_q    <= holdoff_len_i;
        start_phase_o <= phase_idx;
        frame_cnt_o   <= frame_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_burst_sequencer.sv
// Directed bench for rx_burst_sequencer with a countdown-style reference model
// compared every cycle plus hand-computed checkpoints.
module tb_rx_burst_sequencer;
  localparam int PHASES = 16;
  localparam int CNT_W  = 4;
  localparam int CONF_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [PHASES-1:0] det = '0;
  logic [CONF_W-1:0] cl = 4'd1;
  logic [CNT_W-1:0]  capl = 4'd8;
  logic [CNT_W-1:0]  hold = 4'd4;

  logic              capture_en_o, frame_start_o, busy_o;
  logic [3:0]        start_phase_o;
  logic [CNT_W-1:0]  frame_cnt_o;
  logic [2:0]        state_o;

  rx_burst_sequencer #(.PHASES(PHASES), .CNT_W(CNT_W), .CONF_W(CONF_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .detection_i(det),
    .confirm_len_i(cl), .capture_len_i(capl), .holdoff_len_i(hold),
    .capture_en_o(capture_en_o), .frame_start_o(frame_start_o),
    .start_phase_o(start_phase_o), .frame_cnt_o(frame_cnt_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cap_cycles = 0, fs_cycles = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0..4, remaining-cycle countdowns.
  int m_mode = 0, m_conf = 0, m_left = 0, m_hold = 0, m_phase = 0, m_fcnt = 0;
  bit m_fs = 0;

  function automatic int lowest(input logic [PHASES-1:0] d);
    for (int i = 0; i < PHASES; i++) if (d[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit go;
    go = 0;
    if (!rst_n) begin
      m_mode = 0; m_conf = 0; m_left = 0; m_hold = 0; m_phase = 0; m_fcnt = 0; m_fs = 0;
    end else if (!en) begin
      m_mode = 0; m_conf = 0; m_left = 0; m_fs = 0;
    end else begin
      m_fs = 0;
      case (m_mode)
        0: m_mode = 1;
        1: if (det != 0) begin
             m_conf = 1;
             if (cl <= 1) go = 1; else m_mode = 2;
           end
        2: if (det != 0) begin
             m_conf++;
             if (m_conf >= cl) go = 1;
           end else begin
             m_mode = 1; m_conf = 0;
           end
        3: begin
             m_left--;
             if (m_left == 0) begin
               if (m_hold == 0) m_mode = 1;
               else begin m_mode = 4; m_left = m_hold; end
             end
           end
        4: begin
             m_left--;
             if (m_left == 0) m_mode = 1;
           end
        default: m_mode = 0;
      endcase
      if (go) begin
        m_mode  = 3;
        m_left  = (capl == 0) ? 1 : int'(capl);
        m_hold  = hold;
        m_phase = lowest(det);
        m_fcnt  = (m_fcnt + 1) % (1 << CNT_W);
        m_fs    = 1;
        m_conf  = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("state", state_o, m_mode);
    chk("capture_en", capture_en_o, int'(m_mode == 3));
    chk("frame_start", frame_start_o, int'(m_fs));
    chk("start_phase", start_phase_o, m_phase);
    chk("frame_cnt", frame_cnt_o, m_fcnt);
    chk("busy", busy_o, int'(m_mode >= 2));
    if (capture_en_o) cap_cycles++;
    if (frame_start_o) fs_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s_cap, s_fs;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_capture_en", capture_en_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    chk("search_after_enable", state_o, 1);

    // single-cycle detection, confirm 1, capture 8, holdoff 4
    s_cap = cap_cycles; s_fs = fs_cycles;
    cl = 4'd1; capl = 4'd8; hold = 4'd4; det = 16'h0100;
    @(negedge clk); det = '0;
    chk("latency_capture_en", capture_en_o, 1);
    chk("latency_frame_start", frame_start_o, 1);
    repeat (11) @(negedge clk);
    chk("in_holdoff", state_o, 4);
    @(negedge clk);
    chk("back_to_search", state_o, 1);
    chk("cap_len8_cycles", cap_cycles - s_cap, 8);
    chk("one_frame_start", fs_cycles - s_fs, 1);
    chk("phase8", start_phase_o, 8);
    chk("frame_cnt1", frame_cnt_o, 1);

    // aborted confirmation, then full confirmation of 3
    cl = 4'd3; s_fs = fs_cycles; det = 16'h8000;
    repeat (2) @(negedge clk); det = '0;
    repeat (2) @(negedge clk);
    chk("confirm_abort_state", state_o, 1);
    chk("confirm_abort_nostart", fs_cycles - s_fs, 0);
    det = 16'h0006;
    repeat (3) @(negedge clk); det = '0;
    chk("confirm3_capture", state_o, 3);
    chk("confirm3_phase1", start_phase_o, 1);
    chk("frame_cnt2", frame_cnt_o, 2);
    repeat (13) @(negedge clk);

    // detections during capture/holdoff are ignored
    cl = 4'd1; s_fs = fs_cycles; det = 16'h0010;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      det = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      @(negedge clk);
    end
    det = '0;
    repeat (3) @(negedge clk);
    chk("ignore_extra_starts", fs_cycles - s_fs, 1);
    chk("frame_cnt3", frame_cnt_o, 3);
    chk("phase4", start_phase_o, 4);
    chk("ignore_back_search", state_o, 1);

    // enable dropped on 3rd capture cycle of 10
    capl = 4'd10; s_cap = cap_cycles; det = 16'h0001;
    @(negedge clk); det = '0;
    @(negedge clk);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("trunc_capture_en", capture_en_o, 0);
    chk("trunc_state_idle", state_o, 0);
    chk("trunc_frame_cnt4", frame_cnt_o, 4);
    chk("trunc_cap_cycles", cap_cycles - s_cap, 3);
    en = 1'b1;
    repeat (2) @(negedge clk);

    // async reset mid-capture
    capl = 4'd8; det = 16'h0002;
    @(negedge clk); det = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_capture_en", capture_en_o, 0);
    chk("async_state", state_o, 0);
    chk("async_frame_cnt", frame_cnt_o, 0);
    chk("async_busy", busy_o, 0);
    det = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_start_after_reset", frame_start_o, 0);
    chk("search_after_reset", state_o, 1);
    det = '0;
    repeat (2) @(negedge clk);
    det = 16'h0004;
    @(negedge clk); det = '0;
    chk("post_reset_start", frame_start_o, 1);
    chk("post_reset_frame_cnt1", frame_cnt_o, 1);
    chk("post_reset_phase2", start_phase_o, 2);
    repeat (13) @(negedge clk);

    // zero lengths: 1-cycle captures back to back, counter wraps
    capl = 4'd0; hold = 4'd0; cl = 4'd1;
    s_cap = cap_cycles; s_fs = fs_cycles; det = 16'hFFFF;
    for (int i = 0; i < 200 && frame_cnt_o != 4'd15; i++) @(negedge clk);
    chk("reach_cnt15", frame_cnt_o, 15);
    for (int i = 0; i < 10 && frame_cnt_o == 4'd15; i++) @(negedge clk);
    chk("wrap_to_0", frame_cnt_o, 0);
    det = '0;
    repeat (3) @(negedge clk);
    chk("wrap_frames", fs_cycles - s_fs, 15);
    chk("wrap_cap_cycles", cap_cycles - s_cap, 15);
    chk("wrap_search", state_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_burst_sequencer.md
RX_BURST_SEQUENCER -- requirements
Module: rx_burst_sequencer

Interface
REQ-001 SHALL have parameter PHASES, default 16, number of parallel sample phases per clock (width of detection vector).
REQ-002 SHALL have parameter CNT_W, default 16, width of capture/holdoff length counters and frame counter.
REQ-003 SHALL have parameter CONF_W, default 4, width of confirmation counter.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable_i  input  1  sequencer run enable.
REQ-007 SHALL have port detection_i  input  PHASES  per-phase packet-detector decision, bit i = phase i.
REQ-008 SHALL have port confirm_len_i  input  CONF_W  consecutive detecting cycles needed to confirm a packet.
REQ-009 SHALL have port capture_len_i  input  CNT_W  capture window length in cycles.
REQ-010 SHALL have port holdoff_len_i  input  CNT_W  post-capture blanking length in cycles.
REQ-011 SHALL have port capture_en_o  output  1  high during capture window; gates downstream correlator/buffer.
REQ-012 SHALL have port frame_start_o  output  1  one-cycle pulse on first capture cycle.
REQ-013 SHALL have port start_phase_o  output  $clog2(PHASES)  phase index of confirmed detection.
REQ-014 SHALL have port frame_cnt_o  output  CNT_W  count of started frames, wraps.
REQ-015 SHALL have port busy_o  output  1  high in CONFIRM, CAPTURE, HOLDOFF.
REQ-016 SHALL have port state_o  output  3  encoded state: IDLE=0, SEARCH=1, CONFIRM=2, CAPTURE=3, HOLDOFF=4.

Function
REQ-017 SHALL register all outputs; no combinational input-to-output path.
REQ-018 IDLE: all outputs low except frame_cnt_o/start_phase_o hold; enable_i=1 -> SEARCH next cycle.
REQ-019 SEARCH: any detection_i bit set -> CONFIRM with conf count 1, or directly CAPTURE if confirm_len_i <= 1.
REQ-020 CONFIRM: detection_i nonzero increments conf count; reaching confirm_len_i -> CAPTURE; detection_i zero -> SEARCH, count cleared.
REQ-021 start_phase_o SHALL load lowest-index set bit of detection_i in the cycle confirmation completes; held otherwise.
REQ-022 capture_len_i and holdoff_len_i SHALL be latched on the transition into CAPTURE; changes mid-frame ignored.
REQ-023 Latency: with confirm_len_i=1, detection at edge t -> capture_en_o and frame_start_o high after edge t+1.
REQ-024 CAPTURE: capture_en_o high exactly latched capture_len cycles (0 treated as 1), then HOLDOFF.
REQ-025 frame_start_o SHALL pulse only on first CAPTURE cycle; frame_cnt_o increments same cycle, wraps 2^CNT_W-1 -> 0.
REQ-026 HOLDOFF: detection_i ignored for latched holdoff_len cycles, then SEARCH; holdoff_len=0 -> SEARCH directly from CAPTURE end.
REQ-027 enable_i=0 in any state -> IDLE next cycle; capture_en_o drops that edge (capture truncated), counters cleared, frame_cnt_o held.
REQ-028 Detections arriving in CAPTURE or HOLDOFF SHALL NOT queue or extend the window.
REQ-029 Multiple detection bits set simultaneously SHALL count as one detecting cycle; lowest index wins for start_phase_o.

Reset
REQ-030 rst_ni low SHALL immediately force IDLE, all outputs 0, all counters 0, regardless of clock.
REQ-031 Reset deassertion mid-packet SHALL NOT produce frame_start_o until a fresh SEARCH->CAPTURE sequence.

Verification
REQ-032 confirm_len=1, capture_len=8, holdoff=4, detection_i=16'h0100 one cycle -> frame_start_o 1 cycle, capture_en_o 8 cycles, start_phase_o=8, frame_cnt_o=1, SEARCH after 4 holdoff cycles.
REQ-033 confirm_len=3, detection_i nonzero 2 cycles then 0 -> back to SEARCH, no capture; then 3 consecutive cycles of 16'h0006 -> capture, start_phase_o=1.
REQ-034 Detection pulses during CAPTURE and HOLDOFF -> no extra frame_start_o, frame_cnt_o unchanged.
REQ-035 enable_i dropped on 3rd capture cycle of capture_len=10 -> capture_en_o low next edge, state_o=0, frame_cnt_o retained.
REQ-036 rst_ni asserted asynchronously mid-CAPTURE -> outputs 0 without clock edge; after release plus enable_i, normal detection starts frame with frame_cnt_o=1.
REQ-037 capture_len=0, holdoff=0, frame_cnt preloaded via 2^CNT_W frames (or CNT_W=4 build, 16 frames) -> 1-cycle captures, frame_cnt_o wraps to 0.
